// File: rtl/ticket_dispenser.sv
// Ticket/coin dispenser: turns a completed sale or a refund into ticket and
// coin requests with req/ack handshakes and per-request timeout supervision.
//
// state      | meaning
// IDLE       | waiting for a sale or refund edge
// RWAIT      | one cycle for upstream to present the refund amount
// TKT_REQ    | ticket request high, waiting for ticketAck
// TKT_GAP    | one idle cycle between ticket and next request
// COIN_REQ   | large or small coin request high, waiting for coinAck
// COIN_GAP   | one idle cycle between coin and next request
// DONE       | done pulse, then back to IDLE
// FAULT      | ack timeout; held until reset
module ticket_dispenser #(
    parameter int ACK_TIMEOUT = 255,
    parameter int COIN_HI     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ticketFinish,
    input  logic       refundReq,
    input  logic [1:0] ticketCount,
    input  logic [7:0] moneyReturn,
    input  logic       ticketAck,
    input  logic       coinAck,
    output logic       ticketReq,
    output logic       coinHiReq,
    output logic       coinLoReq,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] ticketsIssued,
    output logic [7:0] changeLeft
);

    typedef enum logic [2:0] {
        S_IDLE, S_RWAIT, S_TKT_REQ, S_TKT_GAP,
        S_COIN_REQ, S_COIN_GAP, S_DONE, S_FAULT
    } state_t;

    localparam logic [7:0] C_HI       = 8'(COIN_HI);
    localparam logic [7:0] C_TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     r_state;
    logic       r_tf_q, r_rr_q;
    logic [1:0] r_tkt_left;
    logic [1:0] r_issued;
    logic [7:0] r_change;
    logic [7:0] r_tmo_cnt;
    logic       r_sel_hi;
    logic       r_ticket_req, r_hi_req, r_lo_req;
    logic       r_busy, r_done, r_fault;

    logic       w_sale_start, w_refund_start;
    logic       w_mr_hi, w_cl_hi;
    logic [7:0] w_coin_val;

    // A simultaneous refund edge is dropped in favour of the sale.
    assign w_sale_start   = ticketFinish & ~r_tf_q;
    assign w_refund_start = refundReq & ~r_rr_q & ~w_sale_start;
    assign w_mr_hi        = (moneyReturn >= C_HI);
    assign w_cl_hi        = (r_change >= C_HI);
    assign w_coin_val     = r_sel_hi ? C_HI : 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_tf_q       <= 1'b0;
            r_rr_q       <= 1'b0;
            r_tkt_left   <= 2'd0;
            r_issued     <= 2'd0;
            r_change     <= 8'd0;
            r_tmo_cnt    <= 8'd0;
            r_sel_hi     <= 1'b0;
            r_ticket_req <= 1'b0;
            r_hi_req     <= 1'b0;
            r_lo_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_tf_q <= ticketFinish;
            r_rr_q <= refundReq;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sale_start) begin
                        r_tkt_left <= ticketCount;
                        r_change   <= moneyReturn;
                        r_issued   <= 2'd0;
                        r_busy     <= 1'b1;
                        if (ticketCount != 2'd0) begin
                            r_state      <= S_TKT_REQ;
                            r_ticket_req <= 1'b1;
                            r_tmo_cnt    <= 8'd0;
                        end else if (moneyReturn != 8'd0) begin
                            r_state   <= S_COIN_REQ;
                            r_sel_hi  <= w_mr_hi;
                            r_hi_req  <= w_mr_hi;
                            r_lo_req  <= ~w_mr_hi;
                            r_tmo_cnt <= 8'd0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_refund_start) begin
                        r_state <= S_RWAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_RWAIT: begin
                    r_change   <= moneyReturn;
                    r_tkt_left <= 2'd0;
                    r_issued   <= 2'd0;
                    if (moneyReturn != 8'd0) begin
                        r_state   <= S_COIN_REQ;
                        r_sel_hi  <= w_mr_hi;
                        r_hi_req  <= w_mr_hi;
                        r_lo_req  <= ~w_mr_hi;
                        r_tmo_cnt <= 8'd0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_TKT_REQ: begin
                    if (ticketAck) begin
                        r_ticket_req <= 1'b0;
                        r_tkt_left   <= r_tkt_left - 2'd1;
                        r_issued     <= r_issued + 2'd1;
                        r_state      <= S_TKT_GAP;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_ticket_req <= 1'b0;
                        r_fault      <= 1'b1;
                        r_state      <= S_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_TKT_GAP: begin
                    if (r_tkt_left != 2'd0) begin
                        r_state      <= S_TKT_REQ;
                        r_ticket_req <= 1'b1;
                        r_tmo_cnt    <= 8'd0;
                    end else if (r_change != 8'd0) begin
                        r_state   <= S_COIN_REQ;
                        r_sel_hi  <= w_cl_hi;
                        r_hi_req  <= w_cl_hi;
                        r_lo_req  <= ~w_cl_hi;
                        r_tmo_cnt <= 8'd0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_COIN_REQ: begin
                    // Coin choice was fixed on entry, so this never underflows.
                    if (coinAck) begin
                        r_hi_req <= 1'b0;
                        r_lo_req <= 1'b0;
                        r_change <= r_change - w_coin_val;
                        r_state  <= S_COIN_GAP;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_hi_req <= 1'b0;
                        r_lo_req <= 1'b0;
                        r_fault  <= 1'b1;
                        r_state  <= S_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_COIN_GAP: begin
                    if (r_change != 8'd0) begin
                        r_state   <= S_COIN_REQ;
                        r_sel_hi  <= w_cl_hi;
                        r_hi_req  <= w_cl_hi;
                        r_lo_req  <= ~w_cl_hi;
                        r_tmo_cnt <= 8'd0;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ticketReq     = r_ticket_req;
    assign coinHiReq     = r_hi_req;
    assign coinLoReq     = r_lo_req;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fault         = r_fault;
    assign ticketsIssued = r_issued;
    assign changeLeft    = r_change;

endmodule
